// File: rtl/edge_detector_bank_if.sv
// Event-queue handshake bundle for edge_detector_bank: head entry, occupancy,
// and the valid/ready pop handshake.
interface edge_detector_bank_if #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          evt_valid;
  logic                          evt_ready;
  logic [CHANNELS-1:0]           evt_rise;
  logic [CHANNELS-1:0]           evt_fall;
  logic [$clog2(FIFO_DEPTH):0]   evt_count;

  modport master (
    output evt_valid, evt_rise, evt_fall, evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_rise, evt_fall, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/edge_detector_bank.sv
// Multi-channel debounced edge detector with a buffered event FIFO.
// Define EDGE_DETECTOR_BANK_SYNC_EN to add a two-flop input synchroniser.
module edge_detector_bank #(
  parameter int unsigned         CHANNELS    = 8,
  parameter int unsigned         HOLD_COUNT  = 31,
  parameter logic [CHANNELS-1:0] RESET_LEVEL = '0,
  parameter int unsigned         FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic [CHANNELS-1:0] chan_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rising,
  output logic [CHANNELS-1:0] falling,
  output logic                overflow,
  input  logic                overflow_clr,
  edge_detector_bank_if.master evt
);

  localparam int unsigned CW = $clog2(HOLD_COUNT + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 2 * CHANNELS;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_COUNT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [CHANNELS-1:0] s;

`ifdef EDGE_DETECTOR_BANK_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = signal_in;
`endif

  logic [CW-1:0]       cnt     [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] accept, rise_nxt, fall_nxt;

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      accept[i]  = 1'b0;
      cnt_nxt[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) accept[i] = 1'b1;
        else                    cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  assign rise_nxt = accept &  s & chan_en;
  assign fall_nxt = accept & ~s & chan_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= RESET_LEVEL;
      rising  <= '0;
      falling <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      level   <= level ^ accept;
      rising  <= rise_nxt;
      falling <= fall_nxt;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, full, wr_en, valid_q;
  logic [EW-1:0] wr_data, head_q, head_nxt;

  assign push    = |(rise_nxt | fall_nxt);
  assign full    = (count == FULL_CNT);
  assign pop     = (count != '0) && evt.evt_ready;
  assign wr_en   = push && (!full || pop);
  assign wr_data = {rise_nxt, fall_nxt};
  assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + 1'b1;
    else if (!wr_en && pop) count_nxt = count - 1'b1;
  end

  // Head is registered; bypass the write data when the new head is the slot written this cycle.
  always_comb begin
    head_nxt = '0;
    if (count_nxt != '0)
      head_nxt = (wr_en && (wr_ptr == rd_nxt)) ? wr_data : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_nxt;
      count   <= count_nxt;
      valid_q <= (count_nxt != '0);
      head_q  <= head_nxt;
      if (push && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_count = count;
  assign evt.evt_rise  = head_q[EW-1:CHANNELS];
  assign evt.evt_fall  = head_q[CHANNELS-1:0];

endmodule

// File: tb/tb_edge_detector_bank.sv
// Self-checking bench for edge_detector_bank: directed scenarios then random
// stimulus, all checked each cycle against a sliding-window/queue reference model.
module tb_edge_detector_bank;

  localparam int unsigned CH    = 4;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [3:0]  RL    = 4'b0000;
`ifdef EDGE_DETECTOR_BANK_SYNC_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif
  localparam int unsigned L = HOLD + LAT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] signal_in, chan_en, level, rising, falling;
  logic       overflow, overflow_clr;

  edge_detector_bank_if #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH)) evt_if ();

  edge_detector_bank #(
    .CHANNELS(CH), .HOLD_COUNT(HOLD), .RESET_LEVEL(RL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .signal_in(signal_in), .chan_en(chan_en),
    .level(level), .rising(rising), .falling(falling),
    .overflow(overflow), .overflow_clr(overflow_clr), .evt(evt_if)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: an edge is accepted when the last HOLD samples all differ from the level.
  bit [3:0] m_level, m_rise, m_fall;
  bit       m_ovf;
  bit [3:0] hist [HOLD];
  bit [7:0] q [$];
  bit [3:0] sy1, sy2;

  task automatic model_reset();
    m_level = RL; m_rise = '0; m_fall = '0; m_ovf = 1'b0;
    q.delete();
    for (int k = 0; k < int'(HOLD); k++) hist[k] = RL;
    sy1 = RL; sy2 = RL;
  endtask

  task automatic model_edge(input bit [3:0] sin, input bit [3:0] en, input bit rdy, input bit clr);
    bit [3:0] s, acc;
    bit       pop, push, full;
`ifdef EDGE_DETECTOR_BANK_SYNC_EN
    s = sy2; sy2 = sy1; sy1 = sin;
`else
    s = sin;
`endif
    for (int k = int'(HOLD) - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    acc = 4'hF;
    for (int k = 0; k < int'(HOLD); k++) acc &= hist[k] ^ m_level;
    m_rise  = acc & s & en;
    m_fall  = acc & ~s & en;
    m_level = m_level ^ acc;
    pop  = (q.size() != 0) && rdy;
    push = |(m_rise | m_fall);
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!full || pop) q.push_back({m_rise, m_fall});
    end
    if (push && full && !pop) m_ovf = 1'b1;
    else if (clr)             m_ovf = 1'b0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    bit [3:0] er, ef;
    er = (q.size() != 0) ? q[0][7:4] : 4'h0;
    ef = (q.size() != 0) ? q[0][3:0] : 4'h0;
    cmp({tag, ".level"},     32'(level),            32'(m_level));
    cmp({tag, ".rising"},    32'(rising),           32'(m_rise));
    cmp({tag, ".falling"},   32'(falling),          32'(m_fall));
    cmp({tag, ".evt_valid"}, 32'(evt_if.evt_valid), 32'(q.size() != 0));
    cmp({tag, ".evt_count"}, 32'(evt_if.evt_count), 32'(q.size()));
    cmp({tag, ".evt_rise"},  32'(evt_if.evt_rise),  32'(er));
    cmp({tag, ".evt_fall"},  32'(evt_if.evt_fall),  32'(ef));
    cmp({tag, ".overflow"},  32'(overflow),         32'(m_ovf));
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [3:0] sin, input logic [3:0] en, input logic rdy, input logic clr);
    signal_in = sin; chan_en = en; evt_if.evt_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    model_edge(sin, en, rdy, clr);
    #1 compare_all("step");
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all("rst_async");
    @(posedge clk);
    #1 compare_all("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] sig, en;
    logic       rdy, clr;
    reset_n = 1'b0; signal_in = '0; chan_en = 4'hF;
    evt_if.evt_ready = 1'b0; overflow_clr = 1'b0;
    model_reset();
    #3 compare_all("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // ch0 rises and holds
    repeat (L) step(4'b0001, 4'hF, 1'b0, 1'b0);
    cmp("tp1.rising", 32'(rising), 32'h1);
    cmp("tp1.count",  32'(evt_if.evt_count), 32'd1);
    cmp("tp1.erise",  32'(evt_if.evt_rise), 32'h1);
    step(4'b0001, 4'hF, 1'b0, 1'b0);
    cmp("tp1.pulse_end", 32'(rising), 32'h0);

    // short glitch on ch1 is rejected
    repeat (3) step(4'b0011, 4'hF, 1'b0, 1'b0);
    repeat (L + 2) step(4'b0001, 4'hF, 1'b0, 1'b0);
    cmp("glitch3.level", 32'(level), 32'h1);
    cmp("glitch3.count", 32'(evt_if.evt_count), 32'd1);
    step(4'b0001, 4'hF, 1'b1, 1'b0);

    // a glitch of exactly HOLD samples is accepted (rise then fall)
    repeat (4) step(4'b0011, 4'hF, 1'b0, 1'b0);
    repeat (L + HOLD) step(4'b0001, 4'hF, 1'b0, 1'b0);
    cmp("glitch4.count", 32'(evt_if.evt_count), 32'd2);
    repeat (2) step(4'b0001, 4'hF, 1'b1, 1'b0);

    // ch0 falls and ch2 rises together -> one shared event
    repeat (L) step(4'b0100, 4'hF, 1'b0, 1'b0);
    cmp("shared.count", 32'(evt_if.evt_count), 32'd1);
    cmp("shared.erise", 32'(evt_if.evt_rise), 32'h4);
    cmp("shared.efall", 32'(evt_if.evt_fall), 32'h1);
    step(4'b0100, 4'hF, 1'b1, 1'b0);

    // disabled channel tracks level silently
    repeat (L + 1) step(4'b1100, 4'b0111, 1'b0, 1'b0);
    cmp("disabled.level", 32'(level), 32'hC);
    cmp("disabled.count", 32'(evt_if.evt_count), 32'd0);

    // five separate edges into a 4-deep queue
    for (int e = 0; e < 5; e++)
      repeat (L) step((e % 2 == 0) ? 4'b1101 : 4'b1100, 4'hF, 1'b0, 1'b0);
    cmp("ovf.count", 32'(evt_if.evt_count), 32'd4);
    cmp("ovf.flag",  32'(overflow), 32'd1);
    repeat (L - 1) step(4'b1100, 4'hF, 1'b0, 1'b0);
    step(4'b1100, 4'hF, 1'b1, 1'b0);
    cmp("fullpp.count", 32'(evt_if.evt_count), 32'd4);
    cmp("fullpp.flag",  32'(overflow), 32'd1);
    cmp("fullpp.head",  32'(evt_if.evt_fall), 32'h1);
    step(4'b1100, 4'hF, 1'b0, 1'b1);
    cmp("ovfclr.flag", 32'(overflow), 32'd0);
    repeat (4) step(4'b1100, 4'hF, 1'b1, 1'b0);
    cmp("drain.count", 32'(evt_if.evt_count), 32'd0);

    // reset mid-count with two events queued
    repeat (L) step(4'b1101, 4'hF, 1'b0, 1'b0);
    repeat (L) step(4'b1100, 4'hF, 1'b0, 1'b0);
    repeat (2) step(4'b1110, 4'hF, 1'b0, 1'b0);
    cmp("prerst.count", 32'(evt_if.evt_count), 32'd2);
    reset_mid();
    cmp("rst.level", 32'(level), 32'(RL));
    repeat (L - 1) step(4'b1110, 4'hF, 1'b0, 1'b0);
    cmp("postrst.early", 32'(level), 32'(RL));
    step(4'b1110, 4'hF, 1'b0, 1'b0);
    cmp("postrst.level", 32'(level), 32'hE);

    // randomized phase
    sig = 4'b1110; en = 4'hF;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < int'(CH); c++)
        if ($urandom_range(9) == 0) sig[c] = ~sig[c];
      if ($urandom_range(15) == 0) en = 4'($urandom);
      rdy = ($urandom_range(3) == 0);
      clr = ($urandom_range(15) == 0);
      step(sig, en, rdy, clr);
      if (n == 300) reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
